// File: rtl/sar_search_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared types and constants for the successive-approximation
//                search controller: FSM state encoding, default data width
//                and the width helper for the trial counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold values 0..WIDTH inclusive.
    function automatic int CNT_W(input int width);
        return $clog2(width) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : sar_pkg
`default_nettype wire

// File: rtl/sar_search_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_ctrl_if
//  Description : Bundle between the search controller and its environment.
//                slave  : controller side (consumes start and compare flags,
//                         drives trial value and status/result).
//                master : environment side (drives start, sees the flags
//                         from the comparator and the controller outputs).
//  Signals     : start, cmp_gt, cmp_eq, trial[WIDTH], busy, done,
//                result[WIDTH], trials[CNT_W(WIDTH)]
//  Revision    : 1.0 - initial release
// ============================================================================
interface sar_search_ctrl_if
    import sar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                      start;
    logic                      cmp_gt;
    logic                      cmp_eq;
    logic [WIDTH-1:0]          trial;
    logic                      busy;
    logic                      done;
    logic [WIDTH-1:0]          result;
    logic [CNT_W(WIDTH)-1:0]   trials;

    modport slave (
        input  start,
        input  cmp_gt,
        input  cmp_eq,
        output trial,
        output busy,
        output done,
        output result,
        output trials
    );

    modport master (
        output start,
        input  cmp_gt,
        input  cmp_eq,
        input  trial,
        input  busy,
        input  done,
        input  result,
        input  trials
    );

endinterface : sar_search_ctrl_if
`default_nettype wire

// File: rtl/eightbitcomp.sv
`default_nettype none
// ============================================================================
//  Module      : eightbitcomp
//  Description : 8-bit unsigned magnitude comparator, purely combinational.
//  Ports       : A, B          - operands
//                A_great_B     - A >  B
//                A_equal_B     - A == B
//                A_less_B      - A <  B
//  Revision    : 1.0 - initial release
// ============================================================================
module eightbitcomp (
    input  wire logic [7:0] A,
    input  wire logic [7:0] B,
    output logic            A_great_B,
    output logic            A_equal_B,
    output logic            A_less_B
);

    assign A_great_B = (A >  B);
    assign A_equal_B = (A == B);
    assign A_less_B  = (A <  B);

endmodule : eightbitcomp
`default_nettype wire

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_ctrl
//  Description : Successive-approximation search controller. Drives a trial
//                value to an external combinational comparator, one bit per
//                cycle from the MSB down, and returns the value on the
//                comparator's other input as a registered result. Exits early
//                when the comparator reports equality.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                bus (slave)   - start, cmp_gt, cmp_eq in;
//                                trial, busy, done, result, trials out
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sar_search_ctrl_if.slave   bus
);

    localparam int               c_CNT_W = CNT_W(WIDTH);
    localparam logic [WIDTH-1:0] c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_MSB   = c_ONE << (WIDTH - 1);

    state_t               r_state_q,  w_state_d;
    logic [WIDTH-1:0]     r_trial_q,  w_trial_d;
    logic [WIDTH-1:0]     r_result_q, w_result_d;
    logic [c_CNT_W-1:0]   r_k_q,      w_k_d;
    logic [c_CNT_W-1:0]   r_cnt_q,    w_cnt_d;
    logic                 r_busy_q,   w_busy_d;
    logic                 r_done_q,   w_done_d;

    logic [WIDTH-1:0]     w_bit;    // bit currently under test
    logic [WIDTH-1:0]     w_kept;   // trial after deciding the current bit

    assign w_bit  = c_ONE << r_k_q;
    // A < trial (or inconsistent all-zero flags) clears the bit under test.
    assign w_kept = bus.cmp_gt ? r_trial_q : (r_trial_q & ~w_bit);

    always_comb begin
        w_state_d  = r_state_q;
        w_trial_d  = r_trial_q;
        w_result_d = r_result_q;
        w_k_d      = r_k_q;
        w_cnt_d    = r_cnt_q;
        w_busy_d   = 1'b0;
        w_done_d   = 1'b0;

        case (r_state_q)
            IDLE: begin
                w_trial_d = '0;
                if (bus.start) begin
                    w_state_d = TRIAL;
                    w_trial_d = c_MSB;
                    w_k_d     = c_CNT_W'(WIDTH - 1);
                    w_cnt_d   = c_CNT_W'(1);
                    w_busy_d  = 1'b1;
                end
            end

            TRIAL: begin
                // Equality wins over greater-than when both flags are set.
                if (bus.cmp_eq) begin
                    w_state_d  = DONE;
                    w_result_d = r_trial_q;
                    w_trial_d  = '0;
                    w_done_d   = 1'b1;
                end else if (r_k_q != '0) begin
                    w_trial_d = w_kept | (w_bit >> 1);
                    w_k_d     = r_k_q - c_CNT_W'(1);
                    w_cnt_d   = (r_cnt_q < c_CNT_W'(WIDTH)) ? r_cnt_q + c_CNT_W'(1)
                                                            : r_cnt_q;
                    w_busy_d  = 1'b1;
                end else begin
                    w_state_d  = DONE;
                    w_result_d = w_kept;
                    w_trial_d  = '0;
                    w_done_d   = 1'b1;
                end
            end

            DONE: begin
                // start is deliberately not looked at here.
                w_state_d = IDLE;
                w_trial_d = '0;
            end

            default: begin
                w_state_d = IDLE;
                w_trial_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_trial_q  <= '0;
            r_result_q <= '0;
            r_k_q      <= '0;
            r_cnt_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_trial_q  <= w_trial_d;
            r_result_q <= w_result_d;
            r_k_q      <= w_k_d;
            r_cnt_q    <= w_cnt_d;
            r_busy_q   <= w_busy_d;
            r_done_q   <= w_done_d;
        end
    end

    assign bus.trial  = r_trial_q;
    assign bus.busy   = r_busy_q;
    assign bus.done   = r_done_q;
    assign bus.result = r_result_q;
    assign bus.trials = r_cnt_q;

endmodule : sar_search_ctrl
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_search_ctrl
//  Description : Closed-loop bench: eightbitcomp compares a bench-driven A
//                against the controller's trial value. A table of searches is
//                applied, plus hand-written start-hammering and mid-search
//                reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] a_val;
    logic       cmp_lt;

    int n_checks;
    int n_errors;

    sar_search_ctrl_if #(.WIDTH(8)) bus ();

    sar_search_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    eightbitcomp u_cmp (
        .A         (a_val),
        .B         (bus.trial),
        .A_great_B (bus.cmp_gt),
        .A_equal_B (bus.cmp_eq),
        .A_less_B  (cmp_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] exp_res;
        int         exp_tr;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        int         tr;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Trial value presented on compare cycle j (1-based) when searching for a:
    // the bits of a above the bit under test, plus the bit under test set.
    function automatic int model_trial(input logic [7:0] a, input int j);
        int m;
        if (j < 1 || j > 8) return 0;
        m = 1 << (9 - j);
        return (int'(a) & ~(m - 1) & 255) | (m >> 1);
    endfunction

    task automatic run_search(input logic [7:0] a, input logic [7:0] exp_res,
                              input int exp_tr, input bit hammer);
        bit  seen;
        sb_t e;
        a_val = a;
        @(negedge clk);
        bus.start = 1'b1;
        sb_q.push_back('{exp_res, exp_tr});
        seen = 1'b0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            if (!hammer) bus.start = 1'b0;
            if (bus.done) begin
                seen      = 1'b1;
                bus.start = 1'b0;
                e = sb_q.pop_front();
                check("done_latency", cyc, e.tr + 1);
                check("result", int'(bus.result), int'(e.res));
                check("trials", int'(bus.trials), e.tr);
                check("busy_at_done", int'(bus.busy), 0);
                check("trial_at_done", int'(bus.trial), 0);
            end else begin
                check("busy_in_search", int'(bus.busy), 1);
                check("trial_value", int'(bus.trial), model_trial(a, cyc));
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        check("done_single_pulse", int'(bus.done), 0);
        check("busy_after_done", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        check("result_held", int'(bus.result), int'(exp_res));
        check("idle_trial_zero", int'(bus.trial), 0);
    endtask

    initial begin
        bit got_done;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        a_val     = 8'h00;

        vecs[0] = '{8'h5A, 8'h5A, 7};
        vecs[1] = '{8'h00, 8'h00, 8};
        vecs[2] = '{8'hFF, 8'hFF, 8};
        vecs[3] = '{8'h80, 8'h80, 1};
        vecs[4] = '{8'h01, 8'h01, 8};
        vecs[5] = '{8'h7F, 8'h7F, 8};
        vecs[6] = '{8'hAA, 8'hAA, 7};
        vecs[7] = '{8'h40, 8'h40, 2};
        vecs[8] = '{8'hC0, 8'hC0, 2};
        vecs[9] = '{8'h37, 8'h37, 8};

        repeat (3) @(negedge clk);
        check("rst_trial",  int'(bus.trial),  0);
        check("rst_busy",   int'(bus.busy),   0);
        check("rst_done",   int'(bus.done),   0);
        check("rst_result", int'(bus.result), 0);
        check("rst_trials", int'(bus.trials), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_search(vecs[i].a, vecs[i].exp_res, vecs[i].exp_tr, 1'b0);

        // start held high for the whole search, then a fresh search
        run_search(8'h37, 8'h37, 8, 1'b1);
        run_search(8'h5A, 8'h5A, 7, 1'b0);

        // reset during the fourth trial of a search for 0x5A
        a_val = 8'h5A;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_trial4", int'(bus.trial), 8'h50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_trial",  int'(bus.trial),  0);
        check("abort_busy",   int'(bus.busy),   0);
        check("abort_done",   int'(bus.done),   0);
        check("abort_result", int'(bus.result), 0);
        check("abort_trials", int'(bus.trials), 0);
        got_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) got_done = 1'b1;
        end
        check("no_done_after_abort", int'(got_done), 0);
        run_search(8'h5A, 8'h5A, 7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sar_search_ctrl
`default_nettype wire

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller that pairs with the 8-bit magnitude comparator (eightbitcomp).
- It drives the comparator's B input with a trial value and consumes its greater and equal flags.
- It binary-searches for the unknown value on the comparator's A input and returns it as a registered result.
- Used for threshold discovery and for sweeping calibration values against an external code.

Parameters:
- WIDTH, 8, data width of the trial and result. Must match the comparator width; legal values are 2 to 16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a search. Sampled only in IDLE.
- cmp_gt  input  1  comparator A_great_B (A > trial), combinational from trial.
- cmp_eq  input  1  comparator A_equal_B (A == trial).
- trial  output  WIDTH  value driven to comparator B.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- result  output  WIDTH  found value, held until the next start.
- trials  output  $clog2(WIDTH)+1  number of compare cycles used by the last search.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, trial=0, busy=0, done=0, result=0, trials=0.
  - Reset mid-search aborts immediately; no done pulse is produced.
- States are IDLE, TRIAL and DONE.
- IDLE:
  - trial=0, busy=0.
  - When start=1, go to TRIAL: trial=1<<(WIDTH-1), bit index k=WIDTH-1, trial count=1, busy=1.
- TRIAL (one comparison per cycle; comparator is combinational, so flags are valid in the same cycle as trial):
  - cmp_eq=1 (takes priority over cmp_gt): result=trial, go to DONE. This is the early exit.
  - Else the bit is kept if cmp_gt=1 and cleared if cmp_gt=0 (A < trial).
  - If k>0: trial=(kept value) | (1<<(k-1)), k decrements, trial count increments.
  - If k==0: result=kept value, go to DONE.
  - busy=1 throughout.
- DONE:
  - done=1 for exactly one cycle, busy=0, trial=0.
  - trials holds the count of TRIAL cycles.
  - Next state is IDLE unconditionally; start is ignored in DONE.
- start while busy or in DONE is ignored; there is no restart or queueing.
- Latency:
  - First trial appears the cycle after start is sampled.
  - done asserts at cycle (trials+1) after the start edge.
  - Maximum is WIDTH+1 cycles; minimum is 2 (A = MSB-only value).
- Result equals A exactly, provided A is stable while busy. Stability is the caller's responsibility and is not checked.
- Inconsistent flags:
  - cmp_gt=1 and cmp_eq=1 together are treated as equal.
  - cmp_gt=0 and cmp_eq=0 together are treated as less-than.
- Width rules:
  - The trial value never exceeds 2^WIDTH-1.
  - The trial counter saturates at WIDTH and never wraps.
- All outputs are registered, except that trial is a direct register output feeding the comparator.

Decomposition:
- Package sar_pkg holds:
  - the state enum (IDLE, TRIAL, DONE);
  - the constants DEFAULT_WIDTH=8 and CNT_W(WIDTH)=$clog2(WIDTH)+1.
- No sub-module is needed for the RTL itself.
- The bench instantiates eightbitcomp with A driven by the testbench and B tied to trial, forming the closed loop.

Test Plan:
- A=0x5A, pulse start:
  - trial sequence is 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A.
  - Early exit on equal: result=0x5A, trials=7, done at cycle 8.
- A=0x00: trials walk 0x80 down to 0x01, all less-than; result=0x00, trials=8, done at cycle 9.
- A=0xFF: trial sequence 0x80, 0xC0, ..., 0xFF, with equal on the 8th trial; result=0xFF, trials=8.
- A=0x80: equal on the first trial; result=0x80, trials=1, done at cycle 2, busy high for exactly 1 cycle.
- Start re-asserted on every cycle during a search with A=0x37:
  - the search is unaffected; result=0x37, single done pulse.
  - The next start after returning to IDLE begins a fresh search.
- rst asserted at trial 4 of a search with A=0x5A:
  - next cycle all outputs are 0 and no done pulse occurs.
  - A fresh start afterwards yields result=0x5A.
